// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead add/sub: each stage resolves WIDTH/STAGES bits via group G/P; latency STAGES cycles.
// Back-pressure: a valid result not taken by OUT_READY freezes every stage and drops IN_READY.
module pipe_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] ADDER1,
    input  logic [WIDTH-1:0] ADDER2,
    input  logic             CARRY_I,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY_O,
    output logic             OVERFLOW,
    output logic             ZERO
);
    localparam int NG  = WIDTH / GROUP;
    localparam int NPS = NG / STAGES;
    localparam int SW  = NPS * GROUP;

    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0]            cy_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] sum_q;
    logic [STAGES-1:0]            cy_nx;
    logic [STAGES-1:0]            cm_nx;
    logic [STAGES-1:0][WIDTH-1:0] sum_nx;
    logic                         ovf_q;
    logic                         zero_q;
    logic                         advance;
    logic [WIDTH-1:0]             b_in;
    logic                         c_in;
    logic                         unused_ok;

    assign b_in      = ADDER2 ^ {WIDTH{SUB}};
    assign c_in      = SUB | CARRY_I;
    assign OUT_VALID = vld_q[STAGES-1];
    assign advance   = ~(OUT_VALID & ~OUT_READY);
    assign IN_READY  = advance;

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            localparam int LO = s * SW;
            logic [SW-1:0]    sa;
            logic [SW-1:0]    sb;
            logic [WIDTH-1:0] ps;
            logic             ci;
            logic [NPS-1:0]   grp_g;
            logic [NPS-1:0]   grp_p;
            logic [NPS:0]     gc;
            logic [SW-1:0]    ss;
            logic             cm;
            logic             term;
            logic             acc;
            logic             bc;
            logic             pb;
            logic [WIDTH-1:0] full;

            if (s == 0) begin : g_first
                assign sa = ADDER1[LO +: SW];
                assign sb = b_in[LO +: SW];
                assign ps = '0;
                assign ci = c_in;
            end else begin : g_next
                assign sa = a_q[s-1][LO +: SW];
                assign sb = b_q[s-1][LO +: SW];
                assign ps = sum_q[s-1];
                assign ci = cy_q[s-1];
            end

            always_comb begin
                grp_g = '0;
                grp_p = '0;
                gc    = '0;
                ss    = '0;
                cm    = 1'b0;
                term  = 1'b0;
                acc   = 1'b0;
                bc    = 1'b0;
                pb    = 1'b0;
                for (int k = 0; k < NPS; k++) begin
                    term = 1'b0;
                    acc  = 1'b1;
                    for (int j = 0; j < GROUP; j++) begin
                        pb   = sa[k*GROUP+j] ^ sb[k*GROUP+j];
                        term = (sa[k*GROUP+j] & sb[k*GROUP+j]) | (pb & term);
                        acc  = acc & pb;
                    end
                    grp_g[k] = term;
                    grp_p[k] = acc;
                end
                // Each group carry is a flat sum-of-products over the block G/P terms.
                gc[0] = ci;
                for (int k = 0; k < NPS; k++) begin
                    acc = ci;
                    for (int j = 0; j <= k; j++) acc = acc & grp_p[j];
                    for (int j = 0; j <= k; j++) begin
                        term = grp_g[j];
                        for (int m = j + 1; m <= k; m++) term = term & grp_p[m];
                        acc = acc | term;
                    end
                    gc[k+1] = acc;
                end
                for (int k = 0; k < NPS; k++) begin
                    bc = gc[k];
                    for (int j = 0; j < GROUP; j++) begin
                        pb = sa[k*GROUP+j] ^ sb[k*GROUP+j];
                        ss[k*GROUP+j] = pb ^ bc;
                        if ((k == NPS - 1) && (j == GROUP - 1)) cm = bc;
                        bc = (sa[k*GROUP+j] & sb[k*GROUP+j]) | (pb & bc);
                    end
                end
                full = ps;
                full[LO +: SW] = ss;
            end

            assign sum_nx[s] = full;
            assign cy_nx[s]  = gc[NPS];
            assign cm_nx[s]  = cm;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q  <= '0;
            cy_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            vld_q[0] <= IN_VALID;
            a_q[0]   <= ADDER1;
            b_q[0]   <= b_in;
            sum_q[0] <= sum_nx[0];
            cy_q[0]  <= cy_nx[0];
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                a_q[s]   <= a_q[s-1];
                b_q[s]   <= b_q[s-1];
                sum_q[s] <= sum_nx[s];
                cy_q[s]  <= cy_nx[s];
            end
            ovf_q  <= cm_nx[STAGES-1] ^ cy_nx[STAGES-1];
            zero_q <= ~|sum_nx[STAGES-1];
        end
    end

    // Lower operand bits are consumed by earlier stages; the last copy feeds nothing.
    assign unused_ok = ^{a_q, b_q, cm_nx};

    assign SUM      = sum_q[STAGES-1];
    assign CARRY_O  = cy_q[STAGES-1];
    assign OVERFLOW = ovf_q;
    assign ZERO     = zero_q;
endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Bench for pipe_cla_addsub: four instances (STAGES 1,2,4,8) share stimulus; STAGES=2 also covers back-pressure.
module tb_pipe_cla_addsub;
    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        CARRY_I;
    logic        SUB;
    logic        OUT_READY;
    logic [31:0] ADDER1;
    logic [31:0] ADDER2;
    logic [3:0]  in_rdy;
    logic [3:0]  o_vld;
    logic [3:0]  o_c;
    logic [3:0]  o_ov;
    logic [3:0]  o_z;
    logic [31:0] o_sum [4];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            pipe_cla_addsub #(.WIDTH(32), .GROUP(4), .STAGES(1 << gi)) u_dut (
                .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_rdy[gi]),
                .ADDER1(ADDER1), .ADDER2(ADDER2), .CARRY_I(CARRY_I), .SUB(SUB),
                .OUT_VALID(o_vld[gi]), .OUT_READY(OUT_READY), .SUM(o_sum[gi]),
                .CARRY_O(o_c[gi]), .OVERFLOW(o_ov[gi]), .ZERO(o_z[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One beat into all instances, then confirm each result appears exactly at its latency.
    task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub,
                           input logic [31:0] es, input logic ec, input logic eov);
        @(negedge CLK);
        ADDER1 = a; ADDER2 = b; CARRY_I = ci; SUB = sub;
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        #1;
        check("accept_rdy", in_rdy, 4'hF);
        @(negedge CLK);
        IN_VALID = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("st%0d_vld_cyc%0d", 1 << i, k), o_vld[i], k == (1 << i));
                if (k == (1 << i)) begin
                    check($sformatf("st%0d_sum_%0h", 1 << i, a), o_sum[i], es);
                    check($sformatf("st%0d_cout_%0h", 1 << i, a), o_c[i], ec);
                    check($sformatf("st%0d_ovf_%0h", 1 << i, a), o_ov[i], eov);
                    check($sformatf("st%0d_zero_%0h", 1 << i, a), o_z[i], es == 32'h0);
                end
            end
            if (k < 8) @(negedge CLK);
        end
    endtask

    task automatic run_rand();
        logic [31:0] a, b, bb;
        logic        ci, sub, ov;
        logic [32:0] r;
        a   = $urandom;
        b   = $urandom;
        ci  = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        bb  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, bb} + {32'h0, (sub | ci)};
        ov  = (a[31] == bb[31]) && (r[31] != a[31]);
        run_vec(a, b, ci, sub, r[31:0], r[32], ov);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int          sent;
        int          got;
        int          cyc;
        logic        was_stall;
        logic [31:0] held;

        // Reset with IN_VALID high: nothing may be captured.
        RST = 1'b1; IN_VALID = 1'b1; ADDER1 = 32'hFFFF_FFFF; ADDER2 = 32'hFFFF_FFFF;
        CARRY_I = 1'b1; SUB = 1'b0; OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_vld", o_vld, 4'h0);
        check("rst_sum", o_sum[1], 32'h0);
        check("rst_cout", o_c, 4'h0);
        check("rst_ovf", o_ov, 4'h0);
        check("rst_zero", o_z, 4'h0);
        RST = 1'b0; IN_VALID = 1'b0;
        #1;
        check("rst_in_rdy", in_rdy, 4'hF);
        repeat (3) @(negedge CLK);
        check("rst_no_beat", o_vld, 4'h0);

        // Directed vectors: a, b, carry_in, sub, sum, carry_out, overflow.
        run_vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_vec(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_vec(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_vec(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_vec(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
        run_vec(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        run_vec(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
        run_vec(32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0001_FFFF, 1'b0, 1'b0);
        run_vec(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
        run_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        for (int n = 0; n < 30; n++) run_rand();

        // Back-pressure on the STAGES=2 instance: OUT_READY pattern 1,0,0 repeating.
        sent = 0; got = 0; cyc = 0; was_stall = 1'b0; held = '0;
        CARRY_I = 1'b0; SUB = 1'b0;
        while (got < 6 && cyc < 60) begin
            @(negedge CLK);
            if (was_stall) begin
                check("bp_hold_vld", o_vld[1], 1'b1);
                check("bp_hold_sum", o_sum[1], held);
            end
            OUT_READY = (cyc % 3 == 0);
            IN_VALID  = (sent < 6);
            ADDER1    = 32'(sent + 1);
            ADDER2    = 32'(sent + 1);
            #1;
            check("bp_in_rdy", in_rdy[1], !(o_vld[1] && !OUT_READY));
            if (o_vld[1] && OUT_READY) begin
                check($sformatf("bp_sum%0d", got), o_sum[1], 64'(2 * (got + 1)));
                got++;
            end
            was_stall = o_vld[1] && !OUT_READY;
            held      = o_sum[1];
            if (IN_VALID && in_rdy[1]) sent++;
            cyc++;
        end
        check("bp_sent", sent, 6);
        check("bp_got", got, 6);
        @(negedge CLK);
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        repeat (20) @(negedge CLK);
        check("bp_no_extra", o_vld[1], 1'b0);

        // Reset with two beats in flight: STAGES=4/8 copies must never present them.
        ADDER1 = 32'h11; ADDER2 = 32'h11; IN_VALID = 1'b1;
        @(negedge CLK);
        ADDER1 = 32'h22; ADDER2 = 32'h22;
        @(negedge CLK);
        IN_VALID = 1'b0; RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("mid_rst_vld%0d", k), o_vld, 4'h0);
            @(negedge CLK);
        end
        run_vec(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 32'h0000_0033, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_cla_addsub.md
Name: pipe_cla_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the execute-stage ALU and address generation. Operands are split into GROUP-bit lookahead groups. Groups are distributed across STAGES register stages, with inter-group carries resolved by block generate/propagate. A valid/ready handshake gives one result per cycle at fixed latency, and a back-pressure stall freezes the pipe.

Parameters:
WIDTH, 32, operand/result width in bits; multiple of GROUP
GROUP, 4, bits per lookahead group (block G/P computed per group)
STAGES, 2, pipeline register stages; 1 <= STAGES <= WIDTH/GROUP; WIDTH/GROUP divisible by STAGES

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
IN_VALID  input  1  operand beat valid
IN_READY  output  1  block accepts operand beat this cycle
ADDER1  input  WIDTH  operand A
ADDER2  input  WIDTH  operand B
CARRY_I  input  1  carry-in (ignored when SUB=1)
SUB  input  1  1: A-B (B inverted, carry-in forced 1); 0: A+B+CARRY_I
OUT_VALID  output  1  result valid
OUT_READY  input  1  consumer accepts result
SUM  output  WIDTH  result
CARRY_O  output  1  carry out of MSB (for SUB: 1 = no borrow)
OVERFLOW  output  1  signed overflow: carry into MSB XOR carry out of MSB
ZERO  output  1  SUM == 0

Behaviour:
- Interface: one clock CLK. RST is synchronous and active-high, sampled on the rising edge of CLK.
- Reset: all stage valid bits clear. OUT_VALID=0; SUM, CARRY_O, OVERFLOW, ZERO = 0. IN_READY=1 in the first cycle after RST deasserts.
- Stall: stall = OUT_VALID & ~OUT_READY.
  - IN_READY = ~stall (combinational).
  - During stall every stage register, including its valid bit, holds.
- Advance: when not stalled, every stage shifts forward.
  - Stage 0 captures the input beat with valid = IN_VALID.
  - A beat is transferred when IN_VALID & IN_READY.
- Latency: exactly STAGES cycles from the accepting edge to OUT_VALID=1, absent stall. Throughput is 1 beat/cycle. Bubbles propagate as valid=0.
- Stage partition: NG = WIDTH/GROUP groups, NPS = NG/STAGES groups per stage.
  - Stage s computes SUM bits of groups s*NPS .. s*NPS+NPS-1.
  - Within a stage, group carries come from block G/P lookahead: c(i+1) = G(i) | P(i)&c(i), flattened, not rippled through bits.
  - The stage registers its partial SUM, the carry out of its last group, and the still-unused upper operand bits, already B-inverted for SUB.
- Operand B inversion and carry-in selection happen before stage 0 registers. Carry-in is SUB ? 1 : CARRY_I.
- Flags are computed in the last stage and registered with SUM:
  - CARRY_O = carry out of bit WIDTH-1.
  - OVERFLOW = c(WIDTH-1) ^ c(WIDTH).
  - ZERO from the full registered SUM.
- Output registers change only on advance. Values are held while stalled. Contents are don't-care when OUT_VALID=0, except after reset (zero).
- Simultaneous accept and drain in one cycle is allowed: full-rate streaming with OUT_READY=1.
- RST mid-operation discards all in-flight beats, with no partial output. IN_VALID during the RST cycle is ignored.
- STAGES=1: purely combinational lookahead into one register level; latency 1.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- Reset: RST=1 for 2 cycles with IN_VALID=1 -> OUT_VALID=0, SUM=0, all flags 0, IN_READY=1 after release.
- Add wrap, WIDTH=32, STAGES=2: ADDER1=32'hFFFF_FFFF, ADDER2=32'h1, CARRY_I=0, SUB=0 -> OUT_VALID exactly 2 cycles after accept; SUM=0, CARRY_O=1, ZERO=1, OVERFLOW=0.
- Subtract and overflow: A=32'h8000_0000, B=32'h1, SUB=1 -> SUM=32'h7FFF_FFFF, OVERFLOW=1, CARRY_O=1. Then A=5, B=7, SUB=1 -> SUM=32'hFFFF_FFFE, CARRY_O=0, OVERFLOW=0.
- Cross-group carry chain: A=32'h7FFF_FFFF, B=0, CARRY_I=1 -> SUM=32'h8000_0000, OVERFLOW=1. Carry must cross the stage boundary correctly.
- Back-pressure: stream 6 beats A=i, B=i (i=1..6) with OUT_READY toggled 1,0,0,1,... -> results 2,4,6,8,10,12 in order, none lost or duplicated; IN_READY=0 exactly on stall cycles; SUM stable while stalled.
- Reset mid-flight: accept 2 beats, assert RST before they emerge -> no OUT_VALID for discarded beats; a new beat after reset emerges with latency STAGES. Repeat for STAGES=1, 4, 8 with 1000 random operands against a reference model.
